// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, instruction field positions, widths and fetch state encoding
package cpu_pkg;
  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LI   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hD;
  localparam logic [3:0] OP_BNE  = 4'hE;
  localparam logic [3:0] OP_BLT  = 4'hF;
  typedef enum logic {S_IDLE, S_WAIT} fetch_state_e;
endpackage

// File: rtl/fetch_wait_ctr.sv
// fetch_wait_ctr: saturating wait counter, timeout high once the count reaches WAIT_MAX
//   clk/rst  clock, async active-low reset
//   clr      restart count at 0 (wins over en)
//   en       count one waiting cycle
//   timeout  count == WAIT_MAX
module fetch_wait_ctr #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (en && !timeout) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign timeout = cnt_q == CW'(WAIT_MAX);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction register and imem request/ready handshake with timeout
//   ir_write/pc_write/branch_taken/jump_en  FSM strobes and PC decision
//   imem_req/imem_addr/imem_rdata/imem_ready  instruction memory handshake
//   pc, opcode/rd/rs/imm  PC and IR fields; instr_valid/fetch_busy/fetch_err  status
module fetch_unit import cpu_pkg::*; #(
  parameter int PC_W     = PC_W_DEF,
  parameter int INSTR_W  = INSTR_W_DEF,
  parameter int WAIT_MAX = 15,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_write,
  input  logic               pc_write,
  input  logic               branch_taken,
  input  logic               jump_en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [7:0]         imm,
  output logic               instr_valid,
  output logic               fetch_busy,
  output logic               fetch_err
);
  localparam logic [INSTR_W-1:0] HLT_IR = {OP_HLT, {(INSTR_W-4){1'b0}}};
  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic               start, done, tout, timeout;
  fetch_wait_ctr #(.WAIT_MAX(WAIT_MAX)) u_ctr (
    .clk(clk), .rst(rst), .clr(start), .en(state_q == S_WAIT && !imem_ready), .timeout(timeout)
  );
  always_comb begin
    start   = state_q == S_IDLE && ir_write;
    done    = state_q == S_WAIT && imem_ready;
    tout    = state_q == S_WAIT && !imem_ready && timeout;
    state_d = start ? S_WAIT : (done || tout) ? S_IDLE : state_q;
    addr_d  = start ? pc_q : addr_q;
    busy_d  = start ? 1'b1 : (done || tout) ? 1'b0 : busy_q;
    valid_d = start ? 1'b0 : (done || tout) ? 1'b1 : valid_q;
    ir_d    = done ? imem_rdata : tout ? HLT_IR : ir_q;
    err_d   = err_q | tout;
    pc_d    = !pc_write ? pc_q : (jump_en || branch_taken) ? PC_W'(ir_q[IMM_HI:IMM_LO]) : pc_q + PC_W'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_W'(RESET_PC);
      addr_q  <= '0;
      ir_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign imem_req    = busy_q;
  assign fetch_busy  = busy_q;
  assign imem_addr   = addr_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[OPC_HI:OPC_LO];
  assign rd          = ir_q[RD_HI:RD_LO];
  assign rs          = ir_q[RS_HI:RS_LO];
  assign imm         = ir_q[IMM_HI:IMM_LO];
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0, rst = 0;
  logic ir_write = 0, pc_write = 0, branch_taken = 0, jump_en = 0;
  logic imem_req, imem_ready = 0, instr_valid, fetch_busy, fetch_err;
  logic [7:0] imem_addr, pc, imm;
  logic [15:0] imem_rdata = '0;
  logic [3:0] opcode;
  logic [1:0] rd, rs;
  int n_cmp = 0, n_err = 0, busy_cnt;
  fetch_unit dut (
    .clk(clk), .rst(rst), .ir_write(ir_write), .pc_write(pc_write),
    .branch_taken(branch_taken), .jump_en(jump_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .opcode(opcode), .rd(rd), .rs(rs), .imm(imm),
    .instr_valid(instr_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [15:0] w);
    ir_write = 1;
    step();
    ir_write = 0;
    imem_rdata = w;
    imem_ready = 1;
    step();
    imem_ready = 0;
  endtask
  task automatic pcw(input logic j, input logic b);
    pc_write = 1; jump_en = j; branch_taken = b;
    step();
    pc_write = 0; jump_en = 0; branch_taken = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    step(); step();
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_err", fetch_err, 0);
    check("rst_ir", {opcode, rd, rs, imm}, 16'h0000);
    rst = 1;
    ir_write = 1;
    step();
    ir_write = 0;
    check("f0_req", imem_req, 1);
    check("f0_addr", imem_addr, 8'h00);
    check("f0_busy", fetch_busy, 1);
    imem_rdata = 16'h1A05;
    imem_ready = 1;
    step();
    imem_ready = 0;
    check("f0_opc", opcode, 4'h1);
    check("f0_rd", rd, 2);
    check("f0_rs", rs, 2);
    check("f0_imm", imm, 8'h05);
    check("f0_valid", instr_valid, 1);
    check("f0_req_off", imem_req, 0);
    // three wait cycles
    ir_write = 1;
    imem_rdata = 16'hBEEF;
    step();
    ir_write = 0;
    busy_cnt = fetch_busy ? 1 : 0;
    check("w3_valid0", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (fetch_busy) busy_cnt++;
    end
    check("w3_ir_hold", opcode, 4'h1);
    imem_rdata = 16'h2C33;
    imem_ready = 1;
    step();
    imem_ready = 0;
    if (fetch_busy) busy_cnt++;
    check("w3_busy_cycles", busy_cnt, 4);
    check("w3_opc", opcode, 4'h2);
    check("w3_imm", imm, 8'h33);
    check("w3_err", fetch_err, 0);
    // ready on the timeout cycle: data wins
    ir_write = 1;
    step();
    ir_write = 0;
    for (int i = 0; i < 15; i++) step();
    check("tb_busy", fetch_busy, 1);
    imem_rdata = 16'h3000;
    imem_ready = 1;
    step();
    imem_ready = 0;
    check("tb_opc", opcode, 4'h3);
    check("tb_err", fetch_err, 0);
    // real timeout
    ir_write = 1;
    step();
    ir_write = 0;
    for (int i = 0; i < 15; i++) step();
    check("to_busy15", fetch_busy, 1);
    check("to_err15", fetch_err, 0);
    step();
    check("to_ir", {opcode, rd, rs, imm}, 16'hD000);
    check("to_valid", instr_valid, 1);
    check("to_err", fetch_err, 1);
    check("to_busy", fetch_busy, 0);
    fetch(16'h4111);
    check("sticky_opc", opcode, 4'h4);
    check("sticky_err", fetch_err, 1);
    // PC arithmetic
    pcw(0, 0);
    check("pc_inc", pc, 8'h01);
    fetch(16'hB0FF);
    check("pc_addr1", imem_addr, 8'h01);
    pcw(1, 0);
    check("pc_jmp_ff", pc, 8'hFF);
    pcw(0, 0);
    check("pc_wrap", pc, 8'h00);
    fetch(16'hB010);
    pcw(1, 1);
    check("pc_jmp10", pc, 8'h10);
    fetch(16'hC040);
    check("pc_addr10", imem_addr, 8'h10);
    pcw(0, 1);
    check("pc_br40", pc, 8'h40);
    branch_taken = 1;
    jump_en = 1;
    step();
    branch_taken = 0;
    jump_en = 0;
    check("pc_nowrite", pc, 8'h40);
    fetch(16'hB007);
    pcw(1, 0);
    check("pc_jmp07", pc, 8'h07);
    // overlaps
    ir_write = 1;
    pc_write = 1;
    step();
    check("ov_addr", imem_addr, 8'h07);
    check("ov_pc", pc, 8'h08);
    step();
    ir_write = 0;
    pc_write = 0;
    check("ov_wait_addr", imem_addr, 8'h07);
    check("ov_wait_pc", pc, 8'h09);
    check("ov_wait_req", imem_req, 1);
    #2 rst = 0;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_pc", pc, 8'h00);
    check("arst_err", fetch_err, 0);
    check("arst_addr", imem_addr, 8'h00);
    step();
    rst = 1;
    step();
    check("post_rst_busy", fetch_busy, 0);
    check("post_rst_valid", instr_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
